// File: rtl/recv_a.sv
// recv_a: receive side of the xmit_a byte link.
// Deframes [LEN][payload x LEN][CHK] packets from a strobed byte stream, checks
// length, checksum and inter-byte timeout, buffers payload in a small FIFO
// toward a valid/ready consumer, and pulses done/err once per frame end.
module recv_a #(
    parameter int FIFO_DEPTH = 4,    // payload FIFO entries, power of 2, >= 2
    parameter int MAX_LEN    = 16,   // largest legal LEN value (1..255)
    parameter int TIMEOUT    = 255   // strobe-free cycles tolerated mid-frame (1..255)
) (
    input  logic       recv_a_clk,
    input  logic       recv_a_rst_n,
    input  logic [7:0] recv_a_in1,   // link byte
    input  logic       recv_a_in2,   // link strobe
    output logic [7:0] recv_a_out1,  // payload byte at FIFO head
    output logic       recv_a_out2,  // payload valid
    input  logic       recv_a_rdy,   // consumer ready
    output logic       recv_a_done,  // frame ended good
    output logic       recv_a_err,   // frame aborted or bad
    output logic       recv_a_busy   // FSM not idle
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [8:0] TIMEOUT_B = 9'(TIMEOUT);

    // Frame FSM encoding
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;     // payload bytes still expected
    logic [7:0] sum_q,   sum_d;     // running mod-256 sum of LEN and payload
    logic [7:0] timer_q, timer_d;   // consecutive strobe-low cycles mid-frame
    logic       ovf_q,   ovf_d;     // a payload byte of this frame was dropped
    logic       done_q,  done_d;
    logic       err_q,   err_d;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;   // extra MSB is the wrap bit
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  out1_q,   out1_d;
    logic        out2_q,   out2_d;

    logic        push_req;      // FSM wants to store the current byte
    logic        push_ok;       // byte is actually written
    logic        pop;           // consumer takes the head byte
    logic        full;
    logic        can_accept;    // a push this cycle would land
    logic        next_empty;
    logic [8:0]  timer_inc;

    // FIFO occupancy: the push/pop handshake and the full test
    always_comb begin
        pop        = out2_q && recv_a_rdy;
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // A pop frees a slot in the same cycle, so a full FIFO still
        // accepts when the consumer is draining it.
        can_accept = !full || pop;
        push_ok    = push_req && can_accept;
    end

    // Frame FSM: length check, payload counting, checksum and timeout
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        timer_d   = timer_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        push_req  = 1'b0;
        timer_inc = {1'b0, timer_q} + 9'd1;

        case (state_q)
            S_IDLE: begin
                if (recv_a_in2) begin
                    if (recv_a_in1 == 8'd0 || recv_a_in1 > MAX_LEN_B) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d   = recv_a_in1;
                        sum_d   = recv_a_in1;
                        ovf_d   = 1'b0;
                        timer_d = 8'd0;
                        state_d = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                if (recv_a_in2) begin
                    // A dropped byte still counts toward cnt and sum; the
                    // frame is only marked bad through ovf.
                    push_req = 1'b1;
                    sum_d    = sum_q + recv_a_in1;
                    cnt_d    = cnt_q - 8'd1;
                    timer_d  = 8'd0;
                    if (!can_accept) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q == 8'd1) begin
                        state_d = S_CHECK;
                    end
                end else if (timer_inc == TIMEOUT_B) begin
                    err_d   = 1'b1;
                    timer_d = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_inc[7:0];
                end
            end

            S_CHECK: begin
                if (recv_a_in2) begin
                    if (8'(sum_q + recv_a_in1) == 8'd0 && !ovf_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    timer_d = 8'd0;
                    state_d = S_IDLE;
                end else if (timer_inc == TIMEOUT_B) begin
                    err_d   = 1'b1;
                    timer_d = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_inc[7:0];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and the registered head byte / valid
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        next_empty = (wr_ptr_d == rd_ptr_d);
        out2_d     = !next_empty;

        if (next_empty) begin
            // Head byte holds its last value while nothing is valid.
            out1_d = out1_q;
        end else if (push_ok && wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]) begin
            // The byte being written is the next head: forward it so it is
            // visible the cycle after its strobe.
            out1_d = recv_a_in1;
        end else begin
            out1_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // Control and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge recv_a_clk or negedge recv_a_rst_n) begin
        if (!recv_a_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            sum_q    <= 8'd0;
            timer_q  <= 8'd0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            out1_q   <= 8'd0;
            out2_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of its inputs regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            timer_q  <= timer_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
        end
    end

    // Payload storage write port
    always_ff @(posedge recv_a_clk) begin
        // NOTE: storage is deliberately not reset; the pointers define which
        // entries are meaningful, so stale contents are never observed.
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= recv_a_in1;
        end
    end

    assign recv_a_out1 = out1_q;
    assign recv_a_out2 = out2_q;
    assign recv_a_done = done_q;
    assign recv_a_err  = err_q;
    assign recv_a_busy = (state_q != S_IDLE);

endmodule
